// File: rtl/ifid_hazard_ctrl_pkg.sv
// rtl/ifid_hazard_ctrl_pkg.sv - shared opcodes, IF/ID defaults and FSM encoding
package ifid_hazard_ctrl_pkg;

    localparam logic [4:0]  OP_HALT       = 5'b00000;
    localparam logic [4:0]  OP_NOP        = 5'b00001;
    localparam logic [15:0] DEF_NOP_INSTR = {OP_NOP, 11'd0};
    localparam int          DEF_MAX_STALL = 4;
    localparam int          DEF_CNT_W     = 16;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HOLD   = 2'd1,
        ST_HALTED = 2'd2
    } ifid_state_e;

    // Opcode field of a 16-bit instruction word
    function automatic logic [4:0] opcode_of(input logic [15:0] instr);
        return instr[15:11];
    endfunction

endpackage

// File: rtl/ifid_hazard_ctrl_if.sv
// rtl/ifid_hazard_ctrl_if.sv - fetch/decode/hazard signal bundle around the IF/ID register
interface ifid_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [15:0]      instr_in;
    logic [15:0]      pc_plus2_in;
    logic             fetch_done;
    logic             stall;
    logic             flush;
    logic [15:0]      instr_reg;
    logic [15:0]      pc_plus2_reg;
    logic             valid_reg;
    logic             pc_wr_en;
    logic             idex_bubble;
    logic             halted;
    logic [CNT_W-1:0] stall_cycles;
    logic             stall_timeout;

    // Pipeline side driving fetch results and hazard requests
    modport master (
        output instr_in, pc_plus2_in, fetch_done, stall, flush,
        input  instr_reg, pc_plus2_reg, valid_reg, pc_wr_en, idex_bubble,
               halted, stall_cycles, stall_timeout
    );

    // IF/ID controller side
    modport slave (
        input  instr_in, pc_plus2_in, fetch_done, stall, flush,
        output instr_reg, pc_plus2_reg, valid_reg, pc_wr_en, idex_bubble,
               halted, stall_cycles, stall_timeout
    );
endinterface

// File: rtl/ifid_hazard_ctrl_sat_counter.sv
// rtl/ifid_hazard_ctrl_sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);
    logic [W-1:0] cnt_q;

    // Clear wins over increment; stick at all-ones instead of wrapping
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign cnt = cnt_q;
endmodule

// File: rtl/ifid_hazard_ctrl.sv
// rtl/ifid_hazard_ctrl.sv - IF/ID register, PC write enable, bubble injection and HALT drain
module ifid_hazard_ctrl
    import ifid_hazard_ctrl_pkg::*;
#(
    parameter logic [15:0] NOP_INSTR = DEF_NOP_INSTR,
    parameter logic [4:0]  HALT_OP   = OP_HALT,
    parameter int          MAX_STALL = DEF_MAX_STALL,
    parameter int          CNT_W     = DEF_CNT_W
) (
    input logic               clk,
    input logic               rst,
    ifid_hazard_ctrl_if.slave bus
);
    localparam int              RUN_W     = $clog2(MAX_STALL + 1);
    localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(MAX_STALL);

    ifid_state_e      state_q;
    logic [15:0]      instr_q;
    logic [15:0]      pc_plus2_q;
    logic             valid_q;
    logic             halted_q;
    logic             timeout_q;
    logic [RUN_W-1:0] run_cnt;
    logic [CNT_W-1:0] stall_cnt;
    logic             halt_trig;
    logic             pc_wr_en_d;
    logic             bubble_d;

    // A valid HALT sitting in ID moves on to EX and freezes fetch behind it
    assign halt_trig = (state_q != ST_HALTED) && valid_q &&
                       (opcode_of(instr_q) == HALT_OP) && !bus.stall && !bus.flush;

    // PC enable and bubble follow the same priority as the register update
    always_comb begin
        pc_wr_en_d = 1'b0;
        bubble_d   = 1'b0;
        if (rst) begin
            bubble_d = 1'b1;
        end else if (state_q == ST_HALTED) begin
            pc_wr_en_d = bus.flush;
        end else if (bus.flush) begin
            pc_wr_en_d = 1'b1;
        end else if (bus.stall) begin
            bubble_d = 1'b1;
        end else if (halt_trig) begin
            pc_wr_en_d = 1'b0;
        end else begin
            pc_wr_en_d = bus.fetch_done;
        end
    end

    // IF/ID register and RUN/HOLD/HALTED state; flush beats a stall on the wrong path
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            instr_q    <= NOP_INSTR;
            pc_plus2_q <= '0;
            valid_q    <= 1'b0;
            halted_q   <= 1'b0;
        end else if (bus.flush) begin
            state_q  <= ST_RUN;
            instr_q  <= NOP_INSTR;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            case (state_q)
                ST_HALTED: begin
                    state_q <= ST_HALTED;
                end
                ST_RUN, ST_HOLD: begin
                    if (bus.stall) begin
                        state_q <= ST_HOLD;
                    end else if (halt_trig) begin
                        state_q  <= ST_HALTED;
                        instr_q  <= NOP_INSTR;
                        valid_q  <= 1'b0;
                        halted_q <= 1'b1;
                    end else if (!bus.fetch_done) begin
                        state_q <= ST_RUN;
                        instr_q <= NOP_INSTR;
                        valid_q <= 1'b0;
                    end else begin
                        state_q    <= ST_RUN;
                        instr_q    <= bus.instr_in;
                        pc_plus2_q <= bus.pc_plus2_in;
                        valid_q    <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_RUN;
                end
            endcase
        end
    end

    // Total stalled cycles for perf debug, counted even when a flush wins
    sat_counter #(.W(CNT_W)) u_stall_cycles (
        .clk (clk),
        .rst (rst),
        .inc (bus.stall),
        .clr (1'b0),
        .cnt (stall_cnt)
    );

    // Length of the current uninterrupted stall run
    sat_counter #(.W(RUN_W)) u_run_cnt (
        .clk (clk),
        .rst (rst),
        .inc (bus.stall),
        .clr (!bus.stall),
        .cnt (run_cnt)
    );

    // Sticky watchdog: a stall run that would pass MAX_STALL cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            timeout_q <= 1'b0;
        end else if (bus.stall && (run_cnt >= RUN_LIMIT)) begin
            timeout_q <= 1'b1;
        end
    end

    assign bus.instr_reg     = instr_q;
    assign bus.pc_plus2_reg  = pc_plus2_q;
    assign bus.valid_reg     = valid_q;
    assign bus.pc_wr_en      = pc_wr_en_d;
    assign bus.idex_bubble   = bubble_d;
    assign bus.halted        = halted_q;
    assign bus.stall_cycles  = stall_cnt;
    assign bus.stall_timeout = timeout_q;
endmodule

// File: tb/tb_ifid_hazard_ctrl.sv
// tb/tb_ifid_hazard_ctrl.sv - directed self-checking bench for ifid_hazard_ctrl
module tb_ifid_hazard_ctrl;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    ifid_hazard_ctrl_if #(.CNT_W(16)) bus ();

    ifid_hazard_ctrl #(
        .NOP_INSTR (16'h0800),
        .HALT_OP   (5'b00000),
        .MAX_STALL (4),
        .CNT_W     (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.instr_in = 16'h0000;
        bus.pc_plus2_in = 16'h0000;
        bus.fetch_done = 1'b0;
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        step();
        step();
        chk("rst_instr", 32'(bus.instr_reg), 32'h0800);
        chk("rst_pc", 32'(bus.pc_plus2_reg), 32'h0);
        chk("rst_valid", 32'(bus.valid_reg), 32'h0);
        chk("rst_halted", 32'(bus.halted), 32'h0);
        chk("rst_scnt", 32'(bus.stall_cycles), 32'h0);
        chk("rst_tmo", 32'(bus.stall_timeout), 32'h0);
        chk("rst_pcwe", 32'(bus.pc_wr_en), 32'h0);
        chk("rst_bubble", 32'(bus.idex_bubble), 32'h1);

        // Back-to-back loads
        rst = 1'b0;
        bus.fetch_done = 1'b1;
        bus.instr_in = 16'h4123; bus.pc_plus2_in = 16'h0002;
        #1;
        chk("load_pcwe", 32'(bus.pc_wr_en), 32'h1);
        chk("load_bubble", 32'(bus.idex_bubble), 32'h0);
        step();
        chk("load1_instr", 32'(bus.instr_reg), 32'h4123);
        chk("load1_valid", 32'(bus.valid_reg), 32'h1);
        chk("load1_pc", 32'(bus.pc_plus2_reg), 32'h0002);
        bus.instr_in = 16'h4224; bus.pc_plus2_in = 16'h0004;
        step();
        chk("load2_instr", 32'(bus.instr_reg), 32'h4224);
        bus.instr_in = 16'h8a40; bus.pc_plus2_in = 16'h0006;
        step();
        chk("load3_instr", 32'(bus.instr_reg), 32'h8a40);

        // Two-cycle hazard stall
        bus.stall = 1'b1;
        bus.instr_in = 16'h1111; bus.pc_plus2_in = 16'h0008;
        #1;
        chk("st1_pcwe", 32'(bus.pc_wr_en), 32'h0);
        chk("st1_bubble", 32'(bus.idex_bubble), 32'h1);
        step();
        chk("st1_instr", 32'(bus.instr_reg), 32'h8a40);
        chk("st2_pcwe", 32'(bus.pc_wr_en), 32'h0);
        chk("st2_bubble", 32'(bus.idex_bubble), 32'h1);
        step();
        chk("st2_instr", 32'(bus.instr_reg), 32'h8a40);
        chk("st2_pc", 32'(bus.pc_plus2_reg), 32'h0006);
        chk("st2_scnt", 32'(bus.stall_cycles), 32'd2);
        bus.stall = 1'b0;
        #1;
        chk("unst_pcwe", 32'(bus.pc_wr_en), 32'h1);
        step();
        chk("unst_instr", 32'(bus.instr_reg), 32'h1111);

        // Stall and flush together: flush wins, stall still counted
        bus.stall = 1'b1; bus.flush = 1'b1;
        #1;
        chk("sf_pcwe", 32'(bus.pc_wr_en), 32'h1);
        chk("sf_bubble", 32'(bus.idex_bubble), 32'h0);
        step();
        chk("sf_instr", 32'(bus.instr_reg), 32'h0800);
        chk("sf_valid", 32'(bus.valid_reg), 32'h0);
        chk("sf_scnt", 32'(bus.stall_cycles), 32'd3);
        bus.stall = 1'b0; bus.flush = 1'b0;
        bus.instr_in = 16'h2222; bus.pc_plus2_in = 16'h000a;
        step();
        chk("sf_run_instr", 32'(bus.instr_reg), 32'h2222);

        // Instruction memory not done for 3 cycles
        bus.fetch_done = 1'b0;
        bus.instr_in = 16'h7777; bus.pc_plus2_in = 16'h00ee;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("nd_pcwe", 32'(bus.pc_wr_en), 32'h0);
            chk("nd_bubble", 32'(bus.idex_bubble), 32'h0);
            step();
            chk("nd_instr", 32'(bus.instr_reg), 32'h0800);
            chk("nd_valid", 32'(bus.valid_reg), 32'h0);
            chk("nd_pc_hold", 32'(bus.pc_plus2_reg), 32'h000a);
        end
        bus.fetch_done = 1'b1;
        bus.instr_in = 16'h3333; bus.pc_plus2_in = 16'h000c;
        step();
        chk("nd_resume", 32'(bus.instr_reg), 32'h3333);
        chk("nd_resume_v", 32'(bus.valid_reg), 32'h1);

        // HALT drain
        bus.instr_in = 16'h0000; bus.pc_plus2_in = 16'h000e;
        step();
        chk("halt_ld", 32'(bus.instr_reg), 32'h0000);
        bus.instr_in = 16'h4444; bus.pc_plus2_in = 16'h0010;
        #1;
        chk("halt_trig_pcwe", 32'(bus.pc_wr_en), 32'h0);
        step();
        for (int i = 0; i < 10; i++) begin
            chk("halted", 32'(bus.halted), 32'h1);
            chk("halted_pcwe", 32'(bus.pc_wr_en), 32'h0);
            chk("halted_instr", 32'(bus.instr_reg), 32'h0800);
            step();
        end
        bus.flush = 1'b1;
        #1;
        chk("hflush_pcwe", 32'(bus.pc_wr_en), 32'h1);
        step();
        chk("hflush_halted", 32'(bus.halted), 32'h0);
        bus.flush = 1'b0;
        bus.instr_in = 16'h5555; bus.pc_plus2_in = 16'h0012;
        step();
        chk("hflush_run", 32'(bus.instr_reg), 32'h5555);

        // Stall watchdog: 5 consecutive cycles exceeds MAX_STALL=4
        bus.stall = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("tmo_4", 32'(bus.stall_timeout), 32'h0);
        step();
        chk("tmo_5", 32'(bus.stall_timeout), 32'h1);
        chk("tmo_scnt", 32'(bus.stall_cycles), 32'd8);
        chk("tmo_hold", 32'(bus.instr_reg), 32'h5555);
        bus.stall = 1'b0;
        step();
        chk("tmo_sticky", 32'(bus.stall_timeout), 32'h1);
        rst = 1'b1;
        step();
        chk("tmo_rst", 32'(bus.stall_timeout), 32'h0);
        chk("scnt_rst", 32'(bus.stall_cycles), 32'h0);
        chk("instr_rst", 32'(bus.instr_reg), 32'h0800);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
